if_stage: RTL and testbench
===========================

Name: if_stage

Overview:
- Instruction-fetch stage of the pipelined CPU: owns the architectural PC register and drives it as pc_o into the next-PC logic.
- Each advance cycle it loads the next-PC value (npc_in) back into the PC.
- Fetches from instruction memory over a per-cycle req/ready handshake and buffers a returned word while decode is stalled.
- Drives the IF/ID pipeline register with stall (hold) and flush (bubble) control.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
NOP_INSTR, 32'h0000_0000, instruction word presented in ifid_instr when ifid_valid=0

Ports:
clk  input  1  system clock, all state updates on posedge
rst  input  1  synchronous, active-high reset
npc_in  input  32  next PC from next-PC logic (PC+4 / branch / jump / register target)
pc_o  output  32  current PC register, fed to next-PC logic
imem_req  output  1  fetch request valid this cycle
imem_addr  output  32  fetch address, equals pc_o
imem_ready  input  1  imem_rdata valid this cycle, same-cycle response to imem_req
imem_rdata  input  32  fetched instruction word
stall  input  1  hazard unit: hold PC and IF/ID
flush  input  1  control redirect: drop current fetch, bubble IF/ID, PC<=npc_in
ifid_pc  output  32  PC of instruction in IF/ID
ifid_pc4  output  32  ifid_pc+4, mod 2^32
ifid_instr  output  32  instruction in IF/ID
ifid_valid  output  1  IF/ID holds a real instruction
fetch_count  output  32  number of instructions delivered into IF/ID (wraps)

Behaviour:
- Reset (rst=1 at posedge, any state): pc_o=RESET_PC, state=FETCH, ifid_valid=0, ifid_pc=0, ifid_pc4=0, ifid_instr=NOP_INSTR, fetch_count=0, skid buffer cleared. Reset overrides flush/stall. Mid-HOLD reset discards the buffered word.
- imem_req=1 iff state==FETCH and rst=0. imem_addr=pc_o always, combinational.
- State FETCH, priority flush > stall:
  - flush: PC<=npc_in, ifid_valid<=0, ifid_instr<=NOP_INSTR, rdata ignored, stay FETCH, count unchanged.
  - ready & !stall: IF/ID <= {pc_o, pc_o+4, imem_rdata}, ifid_valid<=1, PC<=npc_in, fetch_count+=1, stay FETCH.
  - ready & stall: skid<={pc_o, imem_rdata}, IF/ID unchanged, PC unchanged, go HOLD.
  - !ready & !stall: ifid_valid<=0 (bubble), PC unchanged, stay FETCH.
  - !ready & stall: everything holds.
- State HOLD, imem_req=0:
  - flush: PC<=npc_in, ifid_valid<=0, skid dropped, go FETCH.
  - stall: hold all.
  - !stall: IF/ID <= skid contents, ifid_valid<=1, PC<=npc_in, fetch_count+=1, go FETCH.
- Latency: fetched word appears in IF/ID 1 cycle after ready (unstalled); PC advances the same edge. Sustained throughput is 1 instr/cycle when ready=1 and stall=0.
- pc_o+4 wraps at 2^32 (FFFF_FFFC -> 0000_0000). fetch_count wraps FFFF_FFFF -> 0.
- Unused state encodings return to FETCH next cycle with no IF/ID update.

Test Plan:
- Reset then ready=1, stall=0, npc_in=pc_o+4 for 3 cycles, rdata=A,B,C -> IF/ID shows (0,A),(4,B),(8,C) on consecutive cycles; pc_o = 4,8,C; fetch_count=3.
- ready=1 with stall=1 at pc=0x10, rdata=D, stall held 2 cycles -> imem_req=0 in HOLD; IF/ID unchanged; release -> IF/ID=(0x10,D), pc_o=npc_in, count+1.
- flush=1 with stall=1 and ready=1, npc_in=0x200 -> pc_o=0x200, ifid_valid=0, ifid_instr=NOP_INSTR, count unchanged, state FETCH.
- ready=0 for 2 cycles at pc=0x40 -> ifid_valid=0 both cycles, pc_o stays 0x40; ready=1, rdata=E -> IF/ID=(0x40,E).
- PC=0xFFFF_FFFC fetch with ready=1 -> ifid_pc4=0x0000_0000. Also rst=1 while in HOLD -> pc_o=RESET_PC, ifid_valid=0, buffered word never delivered.

Source files
------------

// File: rtl/if_stage_if.sv
// Instruction-memory fetch bus: per-cycle request with same-cycle ready/data response.
interface if_stage_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;

    // Fetch stage side: issues requests, consumes returned words
    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rdata
    );

    // Memory side: answers requests
    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rdata
    );
endinterface

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, fetches over the imem handshake,
// parks a returned word in a skid buffer while decode is stalled, and
// drives the IF/ID pipeline register with hold and bubble control.
module if_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] npc_in,
    output logic [31:0] pc_o,
    if_stage_if.master  imem,
    input  logic        stall,
    input  logic        flush,
    output logic [31:0] ifid_pc,
    output logic [31:0] ifid_pc4,
    output logic [31:0] ifid_instr,
    output logic        ifid_valid,
    output logic [31:0] fetch_count
);

    localparam logic [1:0] ST_FETCH = 2'd0;
    localparam logic [1:0] ST_HOLD  = 2'd1;

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ifid_pc_q, ifid_pc_d;
    logic [31:0] ifid_pc4_q, ifid_pc4_d;
    logic [31:0] ifid_instr_q, ifid_instr_d;
    logic        ifid_valid_q, ifid_valid_d;
    logic [31:0] fetch_count_q, fetch_count_d;
    logic [31:0] skid_pc_q, skid_pc_d;
    logic [31:0] skid_instr_q, skid_instr_d;

    // State register and all datapath flops; reset wins over flush/stall
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_FETCH;
            pc_q          <= RESET_PC;
            ifid_pc_q     <= 32'h0;
            ifid_pc4_q    <= 32'h0;
            ifid_instr_q  <= NOP_INSTR;
            ifid_valid_q  <= 1'b0;
            fetch_count_q <= 32'h0;
            skid_pc_q     <= 32'h0;
            skid_instr_q  <= 32'h0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            ifid_pc_q     <= ifid_pc_d;
            ifid_pc4_q    <= ifid_pc4_d;
            ifid_instr_q  <= ifid_instr_d;
            ifid_valid_q  <= ifid_valid_d;
            fetch_count_q <= fetch_count_d;
            skid_pc_q     <= skid_pc_d;
            skid_instr_q  <= skid_instr_d;
        end
    end

    // Next-state: a stalled return parks us in HOLD until decode frees up or a flush
    always_comb begin
        state_d = ST_FETCH;
        case (state_q)
            ST_FETCH: state_d = (!flush && imem.imem_ready && stall) ? ST_HOLD : ST_FETCH;
            ST_HOLD:  state_d = (!flush && stall) ? ST_HOLD : ST_FETCH;
            default:  state_d = ST_FETCH;
        endcase
    end

    // Datapath updates: PC advance, IF/ID load/bubble, skid capture, delivery count
    always_comb begin
        pc_d          = pc_q;
        ifid_pc_d     = ifid_pc_q;
        ifid_pc4_d    = ifid_pc4_q;
        ifid_instr_d  = ifid_instr_q;
        ifid_valid_d  = ifid_valid_q;
        fetch_count_d = fetch_count_q;
        skid_pc_d     = skid_pc_q;
        skid_instr_d  = skid_instr_q;
        case (state_q)
            ST_FETCH: begin
                if (flush) begin
                    pc_d         = npc_in;
                    ifid_valid_d = 1'b0;
                    ifid_instr_d = NOP_INSTR;
                end else if (imem.imem_ready && !stall) begin
                    ifid_pc_d     = pc_q;
                    ifid_pc4_d    = pc_q + 32'd4;
                    ifid_instr_d  = imem.imem_rdata;
                    ifid_valid_d  = 1'b1;
                    pc_d          = npc_in;
                    fetch_count_d = fetch_count_q + 32'd1;
                end else if (imem.imem_ready && stall) begin
                    skid_pc_d    = pc_q;
                    skid_instr_d = imem.imem_rdata;
                end else if (!stall) begin
                    ifid_valid_d = 1'b0;
                    ifid_instr_d = NOP_INSTR;
                end
            end
            ST_HOLD: begin
                if (flush) begin
                    pc_d         = npc_in;
                    ifid_valid_d = 1'b0;
                    ifid_instr_d = NOP_INSTR;
                end else if (!stall) begin
                    ifid_pc_d     = skid_pc_q;
                    ifid_pc4_d    = skid_pc_q + 32'd4;
                    ifid_instr_d  = skid_instr_q;
                    ifid_valid_d  = 1'b1;
                    pc_d          = npc_in;
                    fetch_count_d = fetch_count_q + 32'd1;
                end
            end
            default: ;
        endcase
    end

    // Outputs: request only while fetching and not in reset; address is the live PC
    always_comb begin
        imem.imem_req  = (state_q == ST_FETCH) && !rst;
        imem.imem_addr = pc_q;
    end

    assign pc_o        = pc_q;
    assign ifid_pc     = ifid_pc_q;
    assign ifid_pc4    = ifid_pc4_q;
    assign ifid_instr  = ifid_instr_q;
    assign ifid_valid  = ifid_valid_q;
    assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_if_stage.sv
// Testbench for if_stage: table-driven vectors, hand-written corner sequences,
// and randomized cycles checked against a transaction-level reference model.
module tb_if_stage;

    localparam logic [31:0] NOP = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst, stall, flush;
    logic [31:0] npc_in, pc_o, ifid_pc, ifid_pc4, ifid_instr, fetch_count;
    logic        ifid_valid;

    if_stage_if imem_bus();

    if_stage #(.RESET_PC(32'h0000_0000), .NOP_INSTR(NOP)) dut (
        .clk(clk), .rst(rst), .npc_in(npc_in), .pc_o(pc_o), .imem(imem_bus),
        .stall(stall), .flush(flush), .ifid_pc(ifid_pc), .ifid_pc4(ifid_pc4),
        .ifid_instr(ifid_instr), .ifid_valid(ifid_valid), .fetch_count(fetch_count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int txn   = 0;

    // Reference model: architectural PC, IF/ID contents, and one optional parked word
    logic [31:0] m_pc, m_ipc, m_ipc4, m_instr, m_cnt, m_bpc, m_bword;
    logic        m_valid, m_parked;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h (txn %0d)", name, act, exp, txn);
        end
    endtask

    task automatic deliver(input logic [31:0] p, input logic [31:0] w, input logic [31:0] npc);
        m_ipc   = p;
        m_ipc4  = p + 32'd4;
        m_instr = w;
        m_valid = 1'b1;
        m_cnt   = m_cnt + 32'd1;
        m_pc    = npc;
    endtask

    task automatic bubble();
        m_valid = 1'b0;
        m_instr = NOP;
    endtask

    task automatic model_edge(input logic r, input logic [31:0] npc, input logic rdy,
                              input logic [31:0] rd, input logic st, input logic fl);
        if (r) begin
            m_pc = 32'h0; m_ipc = 32'h0; m_ipc4 = 32'h0; m_instr = NOP;
            m_valid = 1'b0; m_cnt = 32'h0; m_parked = 1'b0;
        end else if (fl) begin
            m_pc = npc;
            m_parked = 1'b0;
            bubble();
        end else if (m_parked) begin
            if (!st) begin
                deliver(m_bpc, m_bword, npc);
                m_parked = 1'b0;
            end
        end else if (rdy && !st) begin
            deliver(m_pc, rd, npc);
        end else if (rdy && st) begin
            m_bpc = m_pc; m_bword = rd; m_parked = 1'b1;
        end else if (!st) begin
            bubble();
        end
    endtask

    // One clock transaction: drive, check the request side, clock, check IF/ID side
    task automatic step(input logic r, input logic [31:0] npc, input logic rdy,
                        input logic [31:0] rd, input logic st, input logic fl);
        rst = r; npc_in = npc; imem_bus.imem_ready = rdy; imem_bus.imem_rdata = rd;
        stall = st; flush = fl;
        #1;
        chk("imem_req",  {31'b0, imem_bus.imem_req}, {31'b0, (!m_parked && !r)});
        chk("imem_addr", imem_bus.imem_addr, m_pc);
        @(posedge clk);
        #1;
        model_edge(r, npc, rdy, rd, st, fl);
        chk("pc_o",        pc_o,        m_pc);
        chk("ifid_valid",  {31'b0, ifid_valid}, {31'b0, m_valid});
        chk("ifid_pc",     ifid_pc,     m_ipc);
        chk("ifid_pc4",    ifid_pc4,    m_ipc4);
        chk("ifid_instr",  ifid_instr,  m_instr);
        chk("fetch_count", fetch_count, m_cnt);
        $display("txn %0d rst=%0b rdy=%0b stall=%0b flush=%0b npc=%h -> pc=%h v=%0b ifid=(%h,%h) cnt=%0d",
                 txn, r, rdy, st, fl, npc, pc_o, ifid_valid, ifid_pc, ifid_instr, fetch_count);
        txn++;
    endtask

    typedef struct {
        logic        r;
        logic [31:0] npc;
        logic        rdy;
        logic [31:0] rd;
        logic        st;
        logic        fl;
        logic [31:0] e_pc;
        logic        e_v;
        logic [31:0] e_ipc;
        logic [31:0] e_instr;
        logic [31:0] e_cnt;
    } vec_t;

    vec_t tbl[4];

    initial begin
        logic [31:0] npc_r;
        // Reset then three back-to-back fetches of A, B, C
        tbl[0] = '{1'b1, 32'h0,  1'b0, 32'h0,         1'b0, 1'b0, 32'h0,  1'b0, 32'h0, NOP,           32'd0};
        tbl[1] = '{1'b0, 32'h4,  1'b1, 32'hAAAA_0001, 1'b0, 1'b0, 32'h4,  1'b1, 32'h0, 32'hAAAA_0001, 32'd1};
        tbl[2] = '{1'b0, 32'h8,  1'b1, 32'hBBBB_0002, 1'b0, 1'b0, 32'h8,  1'b1, 32'h4, 32'hBBBB_0002, 32'd2};
        tbl[3] = '{1'b0, 32'hC,  1'b1, 32'hCCCC_0003, 1'b0, 1'b0, 32'hC,  1'b1, 32'h8, 32'hCCCC_0003, 32'd3};

        // Bring the DUT out of an unknown state before any checks
        rst = 1'b1; stall = 1'b0; flush = 1'b0; npc_in = 32'h0;
        imem_bus.imem_ready = 1'b0; imem_bus.imem_rdata = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        model_edge(1'b1, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);

        for (int i = 0; i < 4; i++) begin
            step(tbl[i].r, tbl[i].npc, tbl[i].rdy, tbl[i].rd, tbl[i].st, tbl[i].fl);
            chk("tbl_pc",    pc_o,        tbl[i].e_pc);
            chk("tbl_valid", {31'b0, ifid_valid}, {31'b0, tbl[i].e_v});
            chk("tbl_ifid_pc", ifid_pc,   tbl[i].e_ipc);
            chk("tbl_instr", ifid_instr,  tbl[i].e_instr);
            chk("tbl_count", fetch_count, tbl[i].e_cnt);
        end

        // Stall with a returned word at 0x10: parked in HOLD for two cycles, then delivered
        step(1'b0, 32'h10, 1'b1, 32'hDDDD_0000, 1'b0, 1'b0);
        step(1'b0, 32'h99, 1'b1, 32'hDDDD_0004, 1'b1, 1'b0);
        chk("hold_req", {31'b0, imem_bus.imem_req}, 32'd0);
        chk("hold_ifid_pc", ifid_pc, 32'hC);
        step(1'b0, 32'h99, 1'b1, 32'h1234_5678, 1'b1, 1'b0);
        chk("hold_pc", pc_o, 32'h10);
        step(1'b0, 32'h14, 1'b0, 32'h0, 1'b0, 1'b0);
        chk("hold_rel_pc", ifid_pc, 32'h10);
        chk("hold_rel_instr", ifid_instr, 32'hDDDD_0004);
        chk("hold_rel_count", fetch_count, 32'd5);
        chk("hold_rel_npc", pc_o, 32'h14);

        // Flush beats stall and ready
        step(1'b0, 32'h200, 1'b1, 32'hEEEE_EEEE, 1'b1, 1'b1);
        chk("flush_pc", pc_o, 32'h200);
        chk("flush_valid", {31'b0, ifid_valid}, 32'd0);
        chk("flush_count", fetch_count, 32'd5);
        #1;
        chk("flush_req", {31'b0, imem_bus.imem_req}, 32'd1);

        // Two not-ready cycles at 0x40 then the word arrives
        step(1'b0, 32'h40, 1'b0, 32'h0, 1'b0, 1'b1);
        step(1'b0, 32'h44, 1'b0, 32'h0, 1'b0, 1'b0);
        step(1'b0, 32'h44, 1'b0, 32'h0, 1'b0, 1'b0);
        chk("nready_pc", pc_o, 32'h40);
        step(1'b0, 32'h44, 1'b1, 32'hE000_000E, 1'b0, 1'b0);
        chk("nready_ifid_pc", ifid_pc, 32'h40);
        chk("nready_instr", ifid_instr, 32'hE000_000E);

        // PC+4 wraps at the top of the address space
        step(1'b0, 32'hFFFF_FFFC, 1'b0, 32'h0, 1'b0, 1'b1);
        step(1'b0, 32'h0, 1'b1, 32'h5555_AAAA, 1'b0, 1'b0);
        chk("wrap_pc4", ifid_pc4, 32'h0);
        chk("wrap_ifid_pc", ifid_pc, 32'hFFFF_FFFC);

        // Reset while a word is parked: it must never surface
        step(1'b0, 32'h80, 1'b1, 32'hBAD0_BAD0, 1'b1, 1'b0);
        step(1'b1, 32'h80, 1'b0, 32'h0, 1'b1, 1'b0);
        chk("rst_hold_pc", pc_o, 32'h0);
        chk("rst_hold_count", fetch_count, 32'd0);
        step(1'b0, 32'h4, 1'b0, 32'h0, 1'b0, 1'b0);
        step(1'b0, 32'h4, 1'b0, 32'h0, 1'b0, 1'b0);
        chk("rst_hold_valid", {31'b0, ifid_valid}, 32'd0);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            npc_r = ($urandom_range(0, 3) == 0) ? ($urandom() & 32'hFFFF_FFFC) : (m_pc + 32'd4);
            step($urandom_range(0, 59) == 0, npc_r, $urandom_range(0, 3) != 0, $urandom(),
                 $urandom_range(0, 3) == 0, $urandom_range(0, 11) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
